// File: rtl/rr_stream_arbiter.sv
// rr_stream_arbiter: round-robin NUM_REQ:1 valid/ready stream arbiter with a single registered output stage.
// Define RR_STREAM_ARB_PKT_LOCK_EN to hold the grant on one requester until its req_last beat is accepted.
module rr_stream_arbiter #(
  parameter int  NUM_REQ    = 4,
  parameter int  DATA_WIDTH = 32,
  localparam int ID_WIDTH   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [ID_WIDTH-1:0]           out_id,
  output logic                          out_last,
  output logic [NUM_REQ-1:0]            grant_oh
);

  function automatic logic [NUM_REQ-1:0] to_onehot(input logic [ID_WIDTH-1:0] idx);
    logic [NUM_REQ-1:0] oh;
    oh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_WIDTH'(i) == idx) begin
        oh[i] = 1'b1;
      end
    end
    return oh;
  endfunction

  function automatic logic [ID_WIDTH-1:0] next_idx(input logic [ID_WIDTH-1:0] idx);
    if (int'(idx) >= NUM_REQ - 1) begin
      return '0;
    end else begin
      return idx + ID_WIDTH'(1);
    end
  endfunction

  // Returns {found, index} of the first valid requester scanning upward from start with wrap.
  function automatic logic [ID_WIDTH:0] rr_pick(input logic [ID_WIDTH-1:0] start,
                                               input logic [NUM_REQ-1:0]  valid);
    logic                found;
    logic [ID_WIDTH-1:0] sel;
    int                  idx;
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(start) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (!found && valid[idx]) begin
        found = 1'b1;
        sel   = ID_WIDTH'(idx);
      end
    end
    return {found, sel};
  endfunction

  logic [ID_WIDTH-1:0]   ptr_q, ptr_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [ID_WIDTH-1:0]   out_id_q, out_id_d;
  logic                  out_last_q, out_last_d;
  logic [NUM_REQ-1:0]    grant_oh_q, grant_oh_d;
`ifdef RR_STREAM_ARB_PKT_LOCK_EN
  logic                  lock_q, lock_d;
  logic [ID_WIDTH-1:0]   lock_id_q, lock_id_d;
`endif

  logic [ID_WIDTH:0]     pick_s;
  logic [ID_WIDTH-1:0]   win_s;
  logic                  any_s;
  logic                  load_s;
  logic                  accept_s;

  // Winner selection; a held lock overrides the round-robin scan.
  always_comb begin
    pick_s = rr_pick(ptr_q, req_valid);
`ifdef RR_STREAM_ARB_PKT_LOCK_EN
    if (lock_q) begin
      any_s = req_valid[lock_id_q];
      win_s = lock_id_q;
    end else begin
      any_s = pick_s[ID_WIDTH];
      win_s = pick_s[ID_WIDTH-1:0];
    end
`else
    any_s = pick_s[ID_WIDTH];
    win_s = pick_s[ID_WIDTH-1:0];
`endif
  end

  // Handshake and next-state for the output stage, pointer and lock.
  always_comb begin
    load_s      = !out_valid_q || out_ready;
    accept_s    = load_s && any_s;
    req_ready   = accept_s ? to_onehot(win_s) : '0;
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    out_last_d  = out_last_q;
    grant_oh_d  = grant_oh_q;
`ifdef RR_STREAM_ARB_PKT_LOCK_EN
    lock_d      = lock_q;
    lock_id_d   = lock_id_q;
`endif
    if (accept_s) begin
      out_valid_d = 1'b1;
      out_data_d  = req_data[int'(win_s)*DATA_WIDTH +: DATA_WIDTH];
      out_id_d    = win_s;
      out_last_d  = req_last[win_s];
      grant_oh_d  = to_onehot(win_s);
`ifdef RR_STREAM_ARB_PKT_LOCK_EN
      // The pointer only moves once the packet completes, so the next packet goes to someone else.
      if (req_last[win_s]) begin
        lock_d = 1'b0;
        ptr_d  = next_idx(win_s);
      end else begin
        lock_d    = 1'b1;
        lock_id_d = win_s;
      end
`else
      ptr_d = next_idx(win_s);
`endif
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      grant_oh_d  = '0;
    end else begin
      out_valid_d = out_valid_q;
      grant_oh_d  = grant_oh_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      out_last_q  <= 1'b0;
      grant_oh_q  <= '0;
`ifdef RR_STREAM_ARB_PKT_LOCK_EN
      lock_q      <= 1'b0;
      lock_id_q   <= '0;
`endif
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      out_last_q  <= out_last_d;
      grant_oh_q  <= grant_oh_d;
`ifdef RR_STREAM_ARB_PKT_LOCK_EN
      lock_q      <= lock_d;
      lock_id_q   <= lock_id_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;
  assign out_last  = out_last_q;
  assign grant_oh  = grant_oh_q;

endmodule

// File: tb/tb_rr_stream_arbiter.sv
// Bench for rr_stream_arbiter: directed literal checks plus random traffic against a behavioural model.
module tb_rr_stream_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid, req_ready, req_last, grant_oh;
  logic [N*DW-1:0] req_data;
  logic            out_valid, out_ready, out_last;
  logic [DW-1:0]   out_data;
  logic [1:0]      out_id;

  logic [2:0]      v3, r3, l3, g3;
  logic [3*DW-1:0] d3;
  logic            ov3, or3, ol3;
  logic [DW-1:0]   od3;
  logic [1:0]      oid3;

  rr_stream_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_last(req_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_id(out_id),
    .out_last(out_last), .grant_oh(grant_oh)
  );

  rr_stream_arbiter #(.NUM_REQ(3), .DATA_WIDTH(DW)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(v3), .req_ready(r3),
    .req_data(d3), .req_last(l3), .out_valid(ov3),
    .out_ready(or3), .out_data(od3), .out_id(oid3),
    .out_last(ol3), .grant_oh(g3)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: what the single output stage must hold, plus pointer and lock.
  bit            m_valid, m_last, m_lock;
  logic [DW-1:0] m_data;
  int            m_id, m_ptr, m_lock_id, m_win;

  function automatic int pick(input logic [N-1:0] v, input int p, input bit lk, input int lid);
    if (lk) return v[lid] ? lid : -1;
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  always_comb m_win = pick(req_valid, m_ptr, m_lock, m_lock_id);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0; m_data <= '0; m_id <= 0; m_last <= 1'b0;
      m_ptr <= 0; m_lock <= 1'b0; m_lock_id <= 0;
    end else if ((!m_valid || out_ready) && m_win >= 0) begin
      m_valid <= 1'b1;
      m_data  <= req_data[m_win*DW +: DW];
      m_id    <= m_win;
      m_last  <= req_last[m_win];
`ifdef RR_STREAM_ARB_PKT_LOCK_EN
      if (req_last[m_win]) begin
        m_lock <= 1'b0;
        m_ptr  <= (m_win + 1) % N;
      end else begin
        m_lock    <= 1'b1;
        m_lock_id <= m_win;
      end
`else
      m_ptr <= (m_win + 1) % N;
`endif
    end else if (m_valid && out_ready) begin
      m_valid <= 1'b0;
    end
  end

  // Every cycle: compare all outputs of the 4-requester instance against the model.
  always @(negedge clk) begin
    #2;
    chk("out_valid", out_valid, m_valid);
    chk("out_data", out_data, m_data);
    chk("out_id", out_id, m_id);
    chk("out_last", out_last, m_last);
    chk("grant_oh", grant_oh, m_valid ? (64'd1 << m_id) : 64'd0);
    chk("req_ready", req_ready, ((!m_valid || out_ready) && m_win >= 0) ? (64'd1 << m_win) : 64'd0);
  end

  initial begin
    int ids[5];
    int exp_ids[5];
    int beats2;
    bit acc;

    req_valid = 4'b0000;
    req_last  = 4'b1111;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = 8'hA0 + 8'(i);
    v3 = 3'b000; l3 = 3'b111; or3 = 1'b1;
    d3 = {8'h32, 8'h31, 8'h30};

    #12;
    chk("rst_valid", out_valid, 64'd0);
    chk("rst_grant", grant_oh, 64'd0);
    chk("rst_id", out_id, 64'd0);
    chk("rst_data", out_data, 64'd0);
    chk("rst_valid3", ov3, 64'd0);

    @(negedge clk); rst_n = 1'b1; req_valid = 4'b1010;
    @(posedge clk); #1;
    chk("first_id", out_id, 64'd1);
    chk("first_grant", grant_oh, 64'b0010);
    chk("first_data", out_data, 64'hA1);

    @(negedge clk); #2;
    chk("pre_reset_valid", out_valid, 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 64'd0);
    chk("async_rst_data", out_data, 64'd0);
    chk("async_rst_id", out_id, 64'd0);
    chk("async_rst_grant", grant_oh, 64'd0);

    @(negedge clk); rst_n = 1'b1; req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("rot_id", out_id, 64'(k % 4));
      chk("rot_data", out_data, 64'hA0 + 64'(k % 4));
      chk("rot_grant", grant_oh, 64'd1 << (k % 4));
    end

    @(negedge clk); out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("bp_valid", out_valid, 64'd1);
      chk("bp_id", out_id, 64'd0);
      chk("bp_data", out_data, 64'hA0);
      chk("bp_ready", req_ready, 64'd0);
    end
    @(negedge clk); out_ready = 1'b1; #1;
    chk("bp_release_ready", req_ready, 64'b0010);
    @(posedge clk); #1;
    chk("nobubble_valid", out_valid, 64'd1);
    chk("nobubble_id", out_id, 64'd1);
    chk("nobubble_data", out_data, 64'hA1);

    @(negedge clk); req_valid = 4'b0000; v3 = 3'b010; #1;
    chk("w3_ready", r3, 64'b010);
    @(posedge clk); #1;
    chk("w3_a_id", oid3, 64'd1);
    @(negedge clk); v3 = 3'b011;
    @(posedge clk); #1;
    chk("w3_wrap_id", oid3, 64'd0);
    chk("w3_wrap_grant", g3, 64'b001);
    chk("w3_wrap_data", od3, 64'h30);
    chk("w3_wrap_last", ol3, 64'd1);
    @(negedge clk); v3 = 3'b111;
    @(posedge clk); #1;
    chk("w3_ptr_id", oid3, 64'd1);
    @(negedge clk); v3 = 3'b000;

    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1; req_valid = 4'b0010; req_last = 4'b1111;
    @(negedge clk);
    beats2 = 0;
    for (int k = 0; k < 5; k++) begin
      req_valid = 4'b0101;
      req_last  = {1'b1, (beats2 == 2), 1'b1, 1'b1};
      #1 acc = req_ready[2];
      @(posedge clk); #1;
      ids[k] = int'(out_id);
      if (acc) beats2++;
      @(negedge clk);
    end
`ifdef RR_STREAM_ARB_PKT_LOCK_EN
    exp_ids = '{2, 2, 2, 0, 2};
`else
    exp_ids = '{2, 0, 2, 0, 2};
`endif
    for (int k = 0; k < 5; k++) chk("pkt_seq_id", 64'(ids[k]), 64'(exp_ids[k]));
    req_valid = 4'b0000;

`ifdef RR_STREAM_ARB_PKT_LOCK_EN
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1; req_valid = 4'b0010; req_last = 4'b0000;
    @(negedge clk); req_valid = 4'b1000; req_last = 4'b1111;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      chk("bubble_valid", out_valid, 64'd0);
      chk("bubble_grant", grant_oh, 64'd0);
    end
    @(negedge clk); req_valid = 4'b1010;
    @(posedge clk); #1;
    chk("bubble_resume_id", out_id, 64'd1);
    chk("bubble_resume_valid", out_valid, 64'd1);
    @(negedge clk); req_valid = 4'b0000;
`endif

    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      req_valid = 4'($urandom);
      req_data  = 32'($urandom);
      req_last  = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 499) == 0) begin
        #3 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
    end

    @(negedge clk); #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/rr_stream_arbiter.md
# rr_stream_arbiter

- Round-robin arbiter that shares one valid/ready stream output between `NUM_REQ` requesters.
- Each cycle it selects one valid requester, computes its one-hot grant and binary index, and registers the winning beat into a single output stage.
- Sits in front of any shared downstream resource, such as a memory port or a single-lane compute unit, where the binary requester ID must travel with the data.

## Interface

Parameters:
- `NUM_REQ`, 4, number of requesters; must be ≥ 1.
- `DATA_WIDTH`, 32, payload width per requester.
- `ID_WIDTH` (localparam), `NUM_REQ > 1 ? $clog2(NUM_REQ) : 1`, width of the binary requester index.

Ports:
- `clk` input 1: sole clock. All state changes on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_valid` input `NUM_REQ`: per-requester beat valid.
- `req_ready` output `NUM_REQ`: per-requester accept. At most one bit is set.
- `req_data` input `NUM_REQ*DATA_WIDTH`: flattened payloads. Requester i occupies bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `req_last` input `NUM_REQ`: per-requester end-of-packet flag.
- `out_valid` output 1: output stage holds a beat.
- `out_ready` input 1: downstream accept.
- `out_data` output `DATA_WIDTH`: registered payload of the winning beat.
- `out_id` output `ID_WIDTH`: binary index of the requester that supplied the beat.
- `out_last` output 1: registered `req_last` of the winning beat.
- `grant_oh` output `NUM_REQ`: registered one-hot of `out_id`. Zero when `out_valid` = 0.

## Operation

- Round-robin pointer `ptr`, range 0..`NUM_REQ`-1.
  - Winner = first index i with `req_valid[i]` = 1, scanning `ptr`, `ptr`+1, …, wrapping from `NUM_REQ`-1 to 0.
- Load enable: `load = !out_valid || out_ready`.
- Handshake:
  - `req_ready` = one-hot(winner) when `load` = 1 and any `req_valid` = 1; otherwise 0.
  - `req_ready` depends combinationally on `req_valid`, `out_valid`, `out_ready` and the lock state. This is permitted; requesters must not make `req_valid` depend on `req_ready`.
- On an accepted beat (`req_valid[w] & req_ready[w]`), at the next edge:
  - `out_data` ← payload w; `out_last` ← `req_last[w]`; `out_id` ← w; `grant_oh` ← one-hot(w); `out_valid` ← 1.
  - `ptr` ← (w+1) mod `NUM_REQ`. See Configuration for the exception.
- On `out_valid & out_ready` with no new accept: `out_valid` ← 0, `grant_oh` ← 0. `out_data`, `out_id` and `out_last` hold their values.
- While `out_valid & !out_ready`, all `out_*` and `grant_oh` are stable and `req_ready` = 0.
- No requests while `load` = 1: `ptr` is unchanged and `out_valid` goes to 0 if the stage drained.
- `NUM_REQ` = 1: `out_id` is always 0 and `ptr` is always 0.

## Timing

- Reset values, applied asynchronously on `rst_n` = 0:
  - `out_valid` = 0, `out_data` = 0, `out_id` = 0, `out_last` = 0, `grant_oh` = 0.
  - `ptr` = 0, lock cleared.
- Latency: a beat accepted at edge N is presented with `out_valid` = 1 after edge N.
- Throughput: one beat per cycle while `out_ready` = 1 and at least one requester is valid. No bubble on back-to-back transfers.
- Simultaneous drain and load: the new beat replaces the old one in the same edge and `out_valid` stays 1.
- Reset mid-operation: any beat in the output stage is discarded, the lock is dropped and `ptr` returns to 0. Requesters must re-present the beat.
- Fairness: with all requesters continuously valid and `out_ready` = 1, grants rotate 0, 1, …, `NUM_REQ`-1, 0.

## Configuration

- Macro `RR_STREAM_ARB_PKT_LOCK_EN`.
- Defined:
  - Accepting a beat with `req_last` = 0 locks the grant to that requester.
  - While locked, only that requester can receive `req_ready`; other requests are ignored even if the locked requester deasserts `req_valid`, which produces bubbles.
  - The lock releases on acceptance of its beat with `req_last` = 1.
  - `ptr` advances to (w+1) mod `NUM_REQ` only on that last beat.
- Undefined:
  - Each beat is arbitrated independently and `ptr` advances on every beat.
  - `req_last` only passes through to `out_last`.

## Test plan

- **Reset:** assert `rst_n` = 0 mid-transfer with `out_valid` = 1 → all outputs 0 asynchronously and `ptr` = 0. After release, with `req_valid` = 4'b1010, the first grant is requester 1.
- **Rotation:** `NUM_REQ` = 4, `req_valid` = 4'b1111 held, `out_ready` = 1, payload = 0xA0+i → `out_id` sequence 0,1,2,3,0 on consecutive cycles, `out_data` 0xA0..0xA3, `grant_oh` 0001, 0010, 0100, 1000.
- **Backpressure:** `out_ready` = 0 for 3 cycles with `out_valid` = 1 → `out_*` stable, `req_ready` = 0. On `out_ready` = 1, the next beat loads in the same edge with no bubble.
- **Wrap, non-power-of-two:** `NUM_REQ` = 3, `ptr` = 2, `req_valid` = 3'b011 → winner 0, then `ptr` = 1.
- **Packet lock (macro defined):** requester 2 sends 3 beats with last on beat 3, requester 0 valid throughout → `out_id` = 2,2,2 then 0. With the macro undefined → 2,0,2,0,2.
- **Locked bubble (macro defined):** requester 1 locked, drops `req_valid` for 2 cycles while requester 3 is valid → no grant to 3, `out_valid` = 0 for 2 cycles, then requester 1 resumes.
